// File: rtl/svo_vram_pkg.sv
// Shared types for the VRAM arbiter: FSM states, read-owner tags and CPU request record layout.
package svo_vram_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_SCAN = 2'd1;
  localparam owner_t OWN_CPU  = 2'd2;

  // Request record is packed MSB-first as {we, addr, wdata}.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/svo_vram_req_fifo.sv
// Synchronous CPU request FIFO with registered full/empty flags and occupancy level.
module svo_vram_req_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A push against a full FIFO is refused even if a pop frees a slot the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == (PTR_W+1)'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/svo_vram_arbiter.sv
// Single-port VRAM arbiter: scanout has priority, a starvation counter forces CPU slots.
// Optional statistics counters are built when SVO_VRAM_ARB_STATS_EN is defined.
module svo_vram_arbiter
  import svo_vram_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req_valid,
  output logic                          cpu_req_ready,
  input  logic                          cpu_req_we,
  input  logic [ADDR_W-1:0]             cpu_req_addr,
  input  logic [DATA_W-1:0]             cpu_req_wdata,
  output logic                          cpu_rd_valid,
  output logic [DATA_W-1:0]             cpu_rd_data,
  input  logic                          scan_req_valid,
  output logic                          scan_req_ready,
  input  logic [ADDR_W-1:0]             scan_req_addr,
  output logic                          scan_rd_valid,
  output logic [DATA_W-1:0]             scan_rd_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SVO_VRAM_ARB_STATS_EN
  ,
  output logic [15:0]                   stat_forced,
  output logic [15:0]                   stat_full
`endif
);

  localparam int REQ_W = req_width(ADDR_W, DATA_W);
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]  fifo_wdata, fifo_rdata;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              grant_scan, grant_cpu, forced;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  owner_t            own_p0_q, own_p1_q;

  assign cpu_req_ready = !fifo_full;
  assign fifo_push     = cpu_req_valid && cpu_req_ready;
  assign fifo_wdata    = {cpu_req_we, cpu_req_addr, cpu_req_wdata};
  assign fifo_pop      = grant_cpu;

  svo_vram_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign head_we    = fifo_rdata[REQ_W-1];
  assign head_addr  = fifo_rdata[DATA_W +: ADDR_W];
  assign head_wdata = fifo_rdata[DATA_W-1:0];

  // Grants are suppressed during reset so every output reads 0 while it is held.
  always_comb begin
    state_d    = ST_ARB;
    grant_scan = 1'b0;
    grant_cpu  = 1'b0;
    forced     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_ARB: begin
          if ((starve_q == STARVE_LIM) && !fifo_empty) begin
            forced    = 1'b1;
            grant_cpu = 1'b1;
            state_d   = ST_HOLD;
          end else if (scan_req_valid) begin
            grant_scan = 1'b1;
          end else if (!fifo_empty) begin
            grant_cpu = 1'b1;
          end
        end
        ST_HOLD: begin
          if (scan_req_valid) begin
            grant_scan = 1'b1;
          end else if (!fifo_empty) begin
            grant_cpu = 1'b1;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_cpu) begin
      starve_d = '0;
    end else if (grant_scan && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign scan_req_ready = grant_scan;

  // Grant stage -> memory command stage (p0), then read-data return stage (p1).
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      own_p0_q    <= OWN_NONE;
      own_p1_q    <= OWN_NONE;
    end else begin
      mem_en_q    <= grant_scan || grant_cpu;
      mem_we_q    <= grant_cpu && head_we;
      mem_addr_q  <= grant_cpu ? head_addr : scan_req_addr;
      mem_wdata_q <= grant_cpu ? head_wdata : '0;
      own_p0_q    <= grant_scan ? OWN_SCAN :
                     (grant_cpu && !head_we) ? OWN_CPU : OWN_NONE;
      own_p1_q    <= own_p0_q;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign scan_rd_valid = (own_p1_q == OWN_SCAN);
  assign cpu_rd_valid  = (own_p1_q == OWN_CPU);
  assign scan_rd_data  = scan_rd_valid ? mem_rdata : '0;
  assign cpu_rd_data   = cpu_rd_valid ? mem_rdata : '0;

`ifdef SVO_VRAM_ARB_STATS_EN
  logic [15:0] stat_forced_q, stat_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_forced_q <= '0;
      stat_full_q   <= '0;
    end else begin
      if (forced && (stat_forced_q != 16'hFFFF)) stat_forced_q <= stat_forced_q + 1'b1;
      if (cpu_req_valid && !cpu_req_ready && (stat_full_q != 16'hFFFF))
        stat_full_q <= stat_full_q + 1'b1;
    end
  end

  assign stat_forced = stat_forced_q;
  assign stat_full   = stat_full_q;
`endif

endmodule

// File: doc/svo_vram_arbiter.md
Name: svo_vram_arbiter

Overview:
- Shares one single-port video RAM (BSRAM, 1-cycle registered read) between two requesters. The first is the Z80 CPU bus side, with reads and writes queued through an internal FIFO. The second is the scanout pixel fetcher in the clk_pixel domain, which feeds svo_tcard/svo_overlay.
- Scanout has priority. A starvation counter guarantees the CPU forward progress.
- Sits between the CPU register interface and the VRAM, inside svo_hdmi, entirely on clk_pixel.

Parameters:
- ADDR_W, 15, VRAM address width.
- DATA_W, 8, VRAM data width.
- FIFO_DEPTH, 4, CPU request FIFO entries; power of two, minimum 2.
- STARVE_MAX, 16, consecutive cycles in which the CPU is denied while its FIFO is non-empty before a CPU slot is forced.

Ports:
- clk  in  1  clk_pixel domain clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  FIFO not full.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_W  CPU address.
- cpu_req_wdata  in  DATA_W  CPU write data.
- cpu_rd_valid  out  1  one-cycle pulse; cpu_rd_data valid.
- cpu_rd_data  out  DATA_W  CPU read result.
- scan_req_valid  in  1  scanout fetch request.
- scan_req_ready  out  1  scanout granted this cycle.
- scan_req_addr  in  ADDR_W  scanout address.
- scan_rd_valid  out  1  one-cycle pulse; scan_rd_data valid.
- scan_rd_data  out  DATA_W  scanout read data.
- mem_en  out  1  VRAM access strobe.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid the cycle after mem_en with mem_we = 0.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: all outputs 0, except cpu_req_ready = 1. FIFO is emptied, starve_cnt = 0, FSM = ARB. Reset mid-operation discards queued requests and in-flight reads; no rd_valid pulse follows reset.
- FIFO push occurs when cpu_req_valid && cpu_req_ready. If push and pop happen in the same cycle while full, the push is still refused: cpu_req_ready reflects the registered full flag only.
- Arbitration is evaluated every cycle in state ARB:
  - Forced CPU: starve_cnt == STARVE_MAX and FIFO non-empty → grant CPU, clear starve_cnt, scan_req_ready = 0.
  - Scanout: otherwise, if scan_req_valid → grant scanout (scan_req_ready = 1). If the FIFO is non-empty, starve_cnt increments, saturating at STARVE_MAX.
  - CPU: otherwise, if the FIFO is non-empty → grant CPU (pop head), clear starve_cnt.
  - Idle: otherwise, mem_en = 0.
- starve_cnt clears whenever the FIFO is empty.
- Grant registration: a grant in cycle N drives mem_en/mem_we/mem_addr/mem_wdata registered in N+1. Read data returns in N+2, signalled by scan_rd_valid or cpu_rd_valid, routed by a 2-stage owner tag pipeline.
- Latency (request to rd_valid): scanout 2 cycles; CPU minimum 3 cycles (push, pop, mem, data). CPU writes produce no rd_valid.
- Ordering: CPU requests complete in FIFO order. A CPU write followed by a CPU read of the same address returns the new data.
- States:
  - ARB: normal arbitration as above.
  - HOLD: entered for exactly one cycle after a forced CPU grant. In HOLD, scanout is again granted if valid. HOLD exists only to prevent two back-to-back forced grants; it then returns to ARB.
- Throughput: one access per cycle. Scanout worst-case stall is 1 cycle per STARVE_MAX+1 cycles.

Optional Feature:
- SVO_VRAM_ARB_STATS_EN defined:
  - Adds outputs stat_forced[15:0], counting forced CPU grants.
  - Adds stat_full[15:0], counting cycles with cpu_req_valid && !cpu_req_ready.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Not defined: the ports are absent and no counter logic is synthesised. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared package svo_vram_pkg:
  - FSM state encoding (ST_ARB, ST_HOLD).
  - Owner tag constants (OWN_NONE, OWN_SCAN, OWN_CPU).
  - Request record layout {we, addr, wdata}.
- One sub-module, svo_vram_req_fifo: synchronous FIFO with registered full/empty and level outputs.

Test Plan:
- Reset: assert reset for 3 cycles mid-burst → outputs 0, cpu_req_ready = 1, fifo_level = 0, no rd_valid afterwards.
- Idle scanout: CPU write 0x1234 = 0xA5, then CPU read 0x1234 with scan_req_valid = 0 → mem write, then cpu_rd_valid with cpu_rd_data = 0xA5 exactly 3 cycles after the read push.
- Scan priority: scan_req_valid held high and 1 CPU read queued → scan_req_ready is high for 16 cycles, deasserts on cycle 17 (forced CPU), scan_rd_valid shows a 1-cycle gap, cpu_rd_valid follows 2 cycles after the grant.
- FIFO full: 5 back-to-back CPU pushes while scanout is continuous → cpu_req_ready drops after the 4th, fifo_level = 4, 5th is held until the forced grant frees an entry.
- Simultaneous events: FIFO full with push and forced pop in the same cycle → push refused, level goes 4 → 3, with stats built stat_full increments by 1.
- Ordering: CPU writes to 0x0010 (0x11), 0x0011 (0x22), then reads both, with random scan_req_valid → reads return 0x11 then 0x22, in order.
